// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: FSM state encoding, RV32I load
// funct3 encodings, the WAIT counter width and a helper that classifies a
// request as illegal/misaligned before any memory access is made.
package load_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Wide enough for any MEM_TIMEOUT up to 256.
  localparam int CNT_W = 8;

  // A load is rejected up front when its funct3 is not a load encoding or
  // when its address is not naturally aligned for the access size.
  function automatic logic load_is_bad(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_unit_align.sv
// Combinational lane select and extension for loads.
// Ports:
//   i_word    - 32-bit word read from memory
//   i_addr_lo - byte offset of the load within the word
//   i_funct3  - RV32I load type
//   o_result  - selected, sign/zero extended value (0 for non-load funct3)
module load_align
  import load_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half-word, then extend according to type.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    o_result = 32'h0000_0000;

    case (i_addr_lo)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase

    half_sel = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  o_result = {24'h000000, byte_sel};
      F3_LH:   o_result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  o_result = {16'h0000, half_sel};
      F3_LW:   o_result = i_word;
      default: o_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding RV32I load unit.
// Accepts one load request, rejects illegal/misaligned ones without touching
// memory, otherwise issues a one-cycle word read, waits (bounded by
// MEM_TIMEOUT cycles) for read data, aligns/extends it and holds the response
// until the consumer accepts it.
// Ports:
//   i_clk, i_rst                     - clock, synchronous active-high reset
//   i_req_*/o_req_ready              - load request handshake (addr, funct3, rd)
//   o_mem_rd_en/o_mem_addr           - word-aligned memory read strobe/address
//   i_mem_rd_data/i_mem_rd_valid     - memory read return
//   o_rsp_*/i_rsp_ready              - response handshake (data, rd, err)
module load_unit
  import load_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic        o_rsp_err
);

  // The counter value seen in the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      aligned_data;

  load_align u_align (
    .i_word    (i_mem_rd_data),
    .i_addr_lo (addr_q[1:0]),
    .i_funct3  (funct3_q),
    .o_result  (aligned_data)
  );

  // Next-state logic. Request fields are only captured in IDLE, so they stay
  // stable for the whole transaction including the held response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d   = i_req_addr;
          funct3_d = i_req_funct3;
          rd_d     = i_req_rd;
          if (load_is_bad(i_req_funct3, i_req_addr[1:0])) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0000_0000;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mem_rd_valid) begin
          rsp_data_d = aligned_data;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_data_d = 32'h0000_0000;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= 32'h0000_0000;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      rsp_data_q <= 32'h0000_0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_mem_rd_en = (state_q == ST_ISSUE);
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_rd    = rd_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit.
module tb_load_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [2:0]  i_req_funct3;
  logic [4:0]  i_req_rd;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_rd_valid;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_rd;
  logic        o_rsp_err;

  int vecCount;
  int missCount;

  load_unit #(.MEM_TIMEOUT(15)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_funct3   (i_req_funct3),
    .i_req_rd       (i_req_rd),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rd_data  (i_mem_rd_data),
    .i_mem_rd_valid (i_mem_rd_valid),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_data     (o_rsp_data),
    .o_rsp_rd       (o_rsp_rd),
    .o_rsp_err      (o_rsp_err)
  );

  // Free-running 10-unit clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge and settle just after it; checks and input
  // changes both happen here, away from the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One comparison: bump the vector count, assert equality, log on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a request for one edge (the accept edge) and then withdraw it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] f3,
                               input logic [4:0] rd);
    i_req_valid  = 1'b1;
    i_req_addr   = addr;
    i_req_funct3 = f3;
    i_req_rd     = rd;
    tick();
    i_req_valid  = 1'b0;
  endtask

  // A complete successful load with data returned in the first WAIT cycle.
  task automatic doLoad(input string tag, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] word, input logic [31:0] expData);
    applyStimulus(addr, f3, rd);
    checkOutput({tag, "_rden"}, {31'd0, o_mem_rd_en}, 32'd1);
    checkOutput({tag, "_maddr"}, o_mem_addr, {addr[31:2], 2'b00});
    tick();
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = word;
    tick();
    i_mem_rd_valid = 1'b0;
    checkOutput({tag, "_vld"}, {31'd0, o_rsp_valid}, 32'd1);
    checkOutput({tag, "_data"}, o_rsp_data, expData);
    checkOutput({tag, "_err"}, {31'd0, o_rsp_err}, 32'd0);
    checkOutput({tag, "_rd"}, {27'd0, o_rsp_rd}, {27'd0, rd});
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    checkOutput({tag, "_idle"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  // Verify every output sits at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rdy"}, {31'd0, o_req_ready}, 32'd1);
    checkOutput({tag, "_rden"}, {31'd0, o_mem_rd_en}, 32'd0);
    checkOutput({tag, "_vld"}, {31'd0, o_rsp_valid}, 32'd0);
    checkOutput({tag, "_data"}, o_rsp_data, 32'd0);
    checkOutput({tag, "_rd"}, {27'd0, o_rsp_rd}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, o_rsp_err}, 32'd0);
    checkOutput({tag, "_maddr"}, o_mem_addr, 32'd0);
  endtask

  // Directed sequence: reset, LW latency, lane/extension cases, early errors,
  // timeout with late data, held response, and reset mid-transaction.
  initial begin
    vecCount       = 0;
    missCount      = 0;
    i_rst          = 1'b1;
    i_req_valid    = 1'b0;
    i_req_addr     = 32'h0;
    i_req_funct3   = 3'b000;
    i_req_rd       = 5'd0;
    i_mem_rd_data  = 32'h0;
    i_mem_rd_valid = 1'b0;
    i_rsp_ready    = 1'b0;
    tick();
    tick();
    checkResetOutputs("rst");
    i_rst = 1'b0;
    tick();

    // LW 0x100 with cycle-by-cycle latency checks.
    applyStimulus(32'h0000_0100, 3'b010, 5'd5);
    checkOutput("lw_t1_rden", {31'd0, o_mem_rd_en}, 32'd1);
    checkOutput("lw_t1_maddr", o_mem_addr, 32'h0000_0100);
    checkOutput("lw_t1_rdy", {31'd0, o_req_ready}, 32'd0);
    tick();
    checkOutput("lw_t2_rden", {31'd0, o_mem_rd_en}, 32'd0);
    checkOutput("lw_t2_vld", {31'd0, o_rsp_valid}, 32'd0);
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = 32'hDEAD_BEEF;
    tick();
    i_mem_rd_valid = 1'b0;
    checkOutput("lw_t3_vld", {31'd0, o_rsp_valid}, 32'd1);
    checkOutput("lw_t3_data", o_rsp_data, 32'hDEAD_BEEF);
    checkOutput("lw_t3_err", {31'd0, o_rsp_err}, 32'd0);
    checkOutput("lw_t3_rd", {27'd0, o_rsp_rd}, 32'd5);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    checkOutput("lw_done_vld", {31'd0, o_rsp_valid}, 32'd0);
    checkOutput("lw_done_rdy", {31'd0, o_req_ready}, 32'd1);

    // Byte/half lane selection and extension.
    doLoad("lb", 32'h0000_0103, 3'b000, 5'd1, 32'h8011_2233, 32'hFFFF_FF80);
    doLoad("lbu", 32'h0000_0103, 3'b100, 5'd2, 32'h8011_2233, 32'h0000_0080);
    doLoad("lhu", 32'h0000_0102, 3'b101, 5'd3, 32'h8011_2233, 32'h0000_8011);
    doLoad("lh", 32'h0000_0102, 3'b001, 5'd4, 32'h8011_2233, 32'hFFFF_8011);
    doLoad("lb0", 32'h0000_0200, 3'b000, 5'd6, 32'h8011_2233, 32'h0000_0033);
    doLoad("lhlo", 32'h0000_0200, 3'b001, 5'd7, 32'h0000_9ABC, 32'hFFFF_9ABC);

    // Misaligned LH: error response one cycle after accept, no memory read.
    applyStimulus(32'h0000_0101, 3'b001, 5'd9);
    checkOutput("mis_vld", {31'd0, o_rsp_valid}, 32'd1);
    checkOutput("mis_err", {31'd0, o_rsp_err}, 32'd1);
    checkOutput("mis_data", o_rsp_data, 32'd0);
    checkOutput("mis_rden", {31'd0, o_mem_rd_en}, 32'd0);
    checkOutput("mis_rd", {27'd0, o_rsp_rd}, 32'd9);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

    // Illegal funct3 and misaligned LW take the same early-error path.
    applyStimulus(32'h0000_0100, 3'b011, 5'd10);
    checkOutput("ill_err", {31'd0, o_rsp_err}, 32'd1);
    checkOutput("ill_rden", {31'd0, o_mem_rd_en}, 32'd0);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    applyStimulus(32'h0000_0102, 3'b010, 5'd11);
    checkOutput("lwmis_err", {31'd0, o_rsp_err}, 32'd1);
    checkOutput("lwmis_vld", {31'd0, o_rsp_valid}, 32'd1);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

    // Timeout: 15 WAIT cycles without data, then an error response.
    applyStimulus(32'h0000_0200, 3'b010, 5'd12);
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      checkOutput($sformatf("to_wait%0d", i), {31'd0, o_rsp_valid}, 32'd0);
    end
    tick();
    checkOutput("to_vld", {31'd0, o_rsp_valid}, 32'd1);
    checkOutput("to_err", {31'd0, o_rsp_err}, 32'd1);
    checkOutput("to_data", o_rsp_data, 32'd0);
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = 32'h1234_5678;
    tick();
    i_mem_rd_valid = 1'b0;
    checkOutput("to_late_data", o_rsp_data, 32'd0);
    checkOutput("to_late_err", {31'd0, o_rsp_err}, 32'd1);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    checkOutput("to_done_rdy", {31'd0, o_req_ready}, 32'd1);

    // Held response with a competing request that must wait for IDLE.
    applyStimulus(32'h0000_0300, 3'b010, 5'd13);
    tick();
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = 32'hCAFE_F00D;
    tick();
    i_mem_rd_valid = 1'b0;
    i_req_valid    = 1'b1;
    i_req_addr     = 32'h0000_0301;
    i_req_funct3   = 3'b100;
    i_req_rd       = 5'd14;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("hold%0d_data", i), o_rsp_data, 32'hCAFE_F00D);
      checkOutput($sformatf("hold%0d_rdy", i), {31'd0, o_req_ready}, 32'd0);
      checkOutput($sformatf("hold%0d_rd", i), {27'd0, o_rsp_rd}, 32'd13);
      tick();
    end
    checkOutput("hold_vld", {31'd0, o_rsp_valid}, 32'd1);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    checkOutput("hs_rdy", {31'd0, o_req_ready}, 32'd1);
    checkOutput("hs_vld", {31'd0, o_rsp_valid}, 32'd0);
    tick();
    i_req_valid = 1'b0;
    checkOutput("next_rden", {31'd0, o_mem_rd_en}, 32'd1);
    checkOutput("next_maddr", o_mem_addr, 32'h0000_0300);
    tick();
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = 32'h0000_AB00;
    tick();
    i_mem_rd_valid = 1'b0;
    checkOutput("next_data", o_rsp_data, 32'h0000_00AB);
    checkOutput("next_rd", {27'd0, o_rsp_rd}, 32'd14);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

    // Reset during WAIT abandons the load; stray data afterwards is ignored.
    applyStimulus(32'h0000_0400, 3'b010, 5'd15);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkResetOutputs("wrst");
    i_mem_rd_valid = 1'b1;
    i_mem_rd_data  = 32'h5555_AAAA;
    tick();
    i_mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stray%0d_vld", i), {31'd0, o_rsp_valid}, 32'd0);
      checkOutput($sformatf("stray%0d_rdy", i), {31'd0, o_req_ready}, 32'd1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
